// File: rtl/bram_rr_arbiter_if.sv
// Request/response bundle between the table clients and bram_rr_arbiter.
// Ports: one write requester (wr_*), NUM_RD packed read requesters (rd_*), init_done status.
// master = requester side, slave = arbiter side.
interface bram_rr_arbiter_if #(
  parameter int NUM_RD = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 48
);
  logic                     init_done;
  logic                     wr_req;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ack;
  logic [NUM_RD-1:0]        rd_req;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_ack;
  logic [NUM_RD-1:0]        rd_valid;
  logic [DATA_W-1:0]        rd_data;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  init_done, wr_ack, rd_ack, rd_valid, rd_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output init_done, wr_ack, rd_ack, rd_valid, rd_data
  );
endinterface

// File: rtl/bram_rr_arbiter.sv
// Single-port table RAM shared by NUM_RD round-robin readers and one write client; zero-cleared after reset.
// Latency: acks are combinational in the grant cycle; read data/valid one cycle after rd_ack.
// Backpressure: requests are held levels; a write never waits more than one read, a read at most 2*NUM_RD cycles.
// Ports: clk, reset (async active-high), bus (slave modport of bram_rr_arbiter_if).
module bram_rr_arbiter #(
  parameter int NUM_RD = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 48
) (
  input  logic                    clk,
  input  logic                    reset,
  bram_rr_arbiter_if.slave        bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = $clog2(NUM_RD);
  // One extra bit so rr_ptr + offset can exceed NUM_RD-1 before the wrap subtract.
  localparam int CW    = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               last_wr_q, last_wr_d;
  logic [NUM_RD-1:0]  rd_valid_q;
  logic [DATA_W-1:0]  rd_data_q;

  logic               wr_ack_c;
  logic [NUM_RD-1:0]  rd_ack_c;
  logic               mem_we, mem_re;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;

  logic               rd_found;
  logic [PTR_W-1:0]   rd_gnt;
  logic [CW-1:0]      cand;
  logic [ADDR_W-1:0]  sel_addr;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Search the requesters in ring order starting at rr_ptr; first hit wins.
  always_comb begin
    rd_found = 1'b0;
    rd_gnt   = '0;
    cand     = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(NUM_RD)) cand = cand - CW'(NUM_RD);
      if (!rd_found && bus.rd_req[cand[PTR_W-1:0]]) begin
        rd_found = 1'b1;
        rd_gnt   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (PTR_W'(i) == rd_gnt) sel_addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    rr_ptr_d   = rr_ptr_q;
    last_wr_d  = last_wr_q;
    wr_ack_c   = 1'b0;
    rd_ack_c   = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = clr_addr_q;
    mem_wdata  = '0;
    case (state_q)
      CLEAR: begin
        mem_we     = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        // A write may not follow a write while any reader is waiting, so
        // under contention writes and reads alternate.
        if (bus.wr_req && (!last_wr_q || !rd_found)) begin
          wr_ack_c  = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = bus.wr_addr;
          mem_wdata = bus.wr_data;
          last_wr_d = 1'b1;
        end else if (rd_found) begin
          rd_ack_c[rd_gnt] = 1'b1;
          mem_re    = 1'b1;
          mem_addr  = sel_addr;
          rr_ptr_d  = (rd_gnt == PTR_W'(NUM_RD - 1)) ? '0 : rd_gnt + 1'b1;
          last_wr_d = 1'b0;
        end else begin
          last_wr_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      rr_ptr_q   <= '0;
      last_wr_q  <= 1'b0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rr_ptr_q   <= rr_ptr_d;
      last_wr_q  <= last_wr_d;
      rd_valid_q <= rd_ack_c;
      if (mem_re) rd_data_q <= mem[mem_addr];
    end
  end

  // RAM array itself has no reset; the CLEAR sweep provides the zero contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign bus.init_done = (state_q == RUN);
  assign bus.wr_ack    = wr_ack_c;
  assign bus.rd_ack    = rd_ack_c;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Testbench for bram_rr_arbiter: directed scenarios plus randomized traffic.
// Expected grants and read data come from a behavioural model (array + ring pointer).
// Read responses are queued at grant time and checked by an independent monitor.
module tb_bram_rr_arbiter;
  localparam int NUM_RD = 3;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 48;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bram_rr_arbiter_if #(.NUM_RD(NUM_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bram_rr_arbiter #(.NUM_RD(NUM_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
    int                due;
  } sb_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [DATA_W-1:0] mdl_mem [DEPTH];
  int                m_rr;
  bit                m_last_wr;
  bit                rp [NUM_RD];
  logic [ADDR_W-1:0] ra [NUM_RD];
  int                rw [NUM_RD];
  bit                wp;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  int                ww;
  sb_t               sb [$];
  logic [DATA_W-1:0] last_data;
  logic [3:0]        obs_vec;
  sb_t               mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) mdl_mem[a] = '0;
    m_rr = 0; m_last_wr = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin rp[i] = 1'b0; ra[i] = '0; rw[i] = 0; end
    wp = 1'b0; wa = '0; wd = '0; ww = 0;
    sb.delete();
    last_data = '0;
  endtask

  task automatic apply();
    bus.wr_req  = wp;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rd_req[i] = rp[i];
      bus.rd_addr[i*ADDR_W +: ADDR_W] = ra[i];
    end
  endtask

  task automatic raise_rd(input int i, input logic [ADDR_W-1:0] a);
    rp[i] = 1'b1; ra[i] = a; rw[i] = 0;
  endtask

  task automatic raise_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wp = 1'b1; wa = a; wd = d; ww = 0;
  endtask

  function automatic bit any_pending();
    bit r = wp;
    for (int i = 0; i < NUM_RD; i++) r |= rp[i];
    return r;
  endfunction

  // -1 = idle, NUM_RD = write, else reader index
  function automatic int exp_grant();
    bit anyr = 1'b0;
    for (int i = 0; i < NUM_RD; i++) anyr |= rp[i];
    if (wp && (!m_last_wr || !anyr)) return NUM_RD;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rp[(m_rr + k) % NUM_RD]) return (m_rr + k) % NUM_RD;
    end
    return -1;
  endfunction

  // One clock: drive pending requests, check the grant, advance the model.
  // Entered and left at posedge + 1.
  task automatic cycle();
    int g;
    logic [3:0] ev;
    apply();
    @(negedge clk);
    g  = exp_grant();
    ev = (g == NUM_RD) ? 4'b1000 : (g >= 0) ? 4'(1 << g) : 4'b0000;
    obs_vec = {bus.wr_ack, bus.rd_ack};
    check("grant", 64'(obs_vec), 64'(ev));
    for (int i = 0; i < NUM_RD; i++) begin
      if (rp[i]) begin
        if (bus.rd_ack[i]) begin
          check("rd_wait_bound", 64'(rw[i] <= 2*NUM_RD), 64'd1);
          rw[i] = 0;
        end else rw[i]++;
      end
    end
    if (wp) begin
      if (bus.wr_ack) begin
        check("wr_wait_bound", 64'(ww <= 2), 64'd1);
        ww = 0;
      end else ww++;
    end
    if (g == NUM_RD) begin
      mdl_mem[wa] = wd; wp = 1'b0; m_last_wr = 1'b1;
    end else if (g >= 0) begin
      sb.push_back('{idx: g, data: mdl_mem[ra[g]], due: cyc + 1});
      rp[g] = 1'b0; m_rr = (g + 1) % NUM_RD; m_last_wr = 1'b0;
    end else begin
      m_last_wr = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (any_pending() && n < 100) begin cycle(); n++; end
    check("drain_done", 64'(any_pending()), 64'd0);
    repeat (2) cycle();
  endtask

  task automatic reset_and_init();
    int cnt;
    reset = 1'b1;
    model_reset();
    apply();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cnt = 0;
    while (!bus.init_done && cnt < 4*DEPTH) begin @(posedge clk); #1; cnt++; end
    check("init_latency", 64'(cnt), 64'(DEPTH));
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    return ($urandom_range(3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(15));
  endfunction

  // Response monitor: every rd_valid must match the oldest queued grant.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rd_valid != '0) begin
        if (sb.size() == 0) begin
          check("rd_valid_unexpected", 64'(bus.rd_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rd_valid_sel", 64'(bus.rd_valid), 64'(1 << mon_e.idx));
          check("rd_data", 64'(bus.rd_data), 64'(mon_e.data));
          check("rd_latency", 64'(cyc), 64'(mon_e.due));
        end
        last_data = bus.rd_data;
      end else begin
        check("rd_data_hold", 64'(bus.rd_data), 64'(last_data));
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          mon_e = sb.pop_front();
          check("rd_valid_missing", 64'(bus.rd_valid), 64'(1 << mon_e.idx));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy;
    model_reset();
    apply();
    #1;
    check("rst_init_done", 64'(bus.init_done), 64'd0);
    check("rst_wr_ack",    64'(bus.wr_ack),    64'd0);
    check("rst_rd_ack",    64'(bus.rd_ack),    64'd0);
    check("rst_rd_valid",  64'(bus.rd_valid),  64'd0);
    check("rst_rd_data",   64'(bus.rd_data),   64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Requests during CLEAR must not be acknowledged; then reset mid-sweep.
    bus.rd_req = '1; bus.wr_req = 1'b1;
    busy = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.wr_ack || bus.rd_ack != '0 || bus.init_done) busy = 1'b1;
    end
    check("clear_no_ack", 64'(busy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midclr_init_done", 64'(bus.init_done), 64'd0);
    check("midclr_rd_ack",    64'(bus.rd_ack),    64'd0);
    reset_and_init();

    // Cleared contents at low, mid and top addresses
    raise_rd(0, 8'h00); raise_rd(1, 8'h7F); raise_rd(2, 8'hFF);
    drain();

    // Round-robin with all readers held
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NUM_RD; i++) if (!rp[i]) raise_rd(i, rand_addr());
      cycle();
      check("rr_order", 64'(obs_vec), 64'(1 << (k % 3)));
    end
    drain();

    // Write and reader 1 held together alternate
    for (int k = 0; k < 4; k++) begin
      if (!wp) raise_wr(rand_addr(), DATA_W'({$urandom, $urandom}));
      if (!rp[1]) raise_rd(1, rand_addr());
      cycle();
      check("wr_rd_alternate", 64'(obs_vec), (k % 2 == 0) ? 64'h8 : 64'h2);
    end
    drain();

    // Write then read back
    raise_wr(8'h10, 48'h0011_2233_4455);
    cycle();
    raise_rd(0, 8'h10);
    cycle();
    check("wr_then_rd_valid", 64'(bus.rd_valid), 64'b001);
    check("wr_then_rd_data",  64'(bus.rd_data),  64'h0011_2233_4455);
    drain();

    // Read in the cycle right after a write to the same address
    raise_wr(8'h05, 48'hA5A5_0000_5A5A);
    raise_rd(2, 8'h05);
    cycle();
    cycle();
    check("collision_valid", 64'(bus.rd_valid), 64'b100);
    check("collision_data",  64'(bus.rd_data),  64'hA5A5_0000_5A5A);
    drain();

    // Reset while a read response is on the bus
    raise_rd(0, 8'h10);
    cycle();
    check("inflight_valid", 64'(bus.rd_valid), 64'b001);
    reset = 1'b1;
    #1;
    check("inflight_drop_valid", 64'(bus.rd_valid),  64'd0);
    check("inflight_drop_data",  64'(bus.rd_data),   64'd0);
    check("inflight_init_done",  64'(bus.init_done), 64'd0);
    reset_and_init();
    raise_rd(0, 8'h10);
    cycle();
    check("recleared_data", 64'(bus.rd_data), 64'd0);
    drain();

    // Randomized traffic
    repeat (3000) begin
      for (int i = 0; i < NUM_RD; i++) if (!rp[i] && $urandom_range(2) == 0) raise_rd(i, rand_addr());
      if (!wp && $urandom_range(3) == 0) raise_wr(rand_addr(), DATA_W'({$urandom, $urandom}));
      cycle();
    end
    drain();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
